// File: rtl/vga_scanout.sv
// vga_scanout: display-refresh stage on VRAM port B.
//   Generates VGA timing (default 640x480@60 with a 4:1 clock divider) and
//   streams the framebuffer as 12-bit RGB. Each 32-bit VRAM word holds two
//   RGB565 pixels: the low half is the even pixel and the high half is the odd one.
// Ports:
//   clka        system clock, all logic on posedge
//   rstn        asynchronous active-low reset
//   disp_en     1 = show framebuffer, 0 = force black (timing keeps running)
//   vram_addrb  VRAM port B word address
//   vram_doutb  VRAM port B data, valid one clka after the address
//   vga_r/g/b   registered colour, 0 during blanking
//   vga_hs/vs   registered syncs, active low
//   frame_start one-clka pulse on the tick that enters (h=0,v=0)
module vga_scanout #(
  parameter int          CLK_DIV = 4,
  parameter logic [17:0] FB_BASE = '0,
  parameter int          H_VIS   = 640,
  parameter int          H_FP    = 16,
  parameter int          H_SYNC  = 96,
  parameter int          H_BP    = 48,
  parameter int          V_VIS   = 480,
  parameter int          V_FP    = 10,
  parameter int          V_SYNC  = 2,
  parameter int          V_BP    = 33
) (
  input  logic        clka,
  input  logic        rstn,
  input  logic        disp_en,
  output logic [17:0] vram_addrb,
  input  logic [31:0] vram_doutb,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW = $clog2(CLK_DIV);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_CAP  = DW'(1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_W  = HW'(H_VIS);
  localparam logic [VW-1:0] V_VIS_W  = VW'(V_VIS);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic [17:0]   fetch_addr;
  logic [31:0]   prefetch, word_buf;
  logic          tick, h_wrap, v_wrap;
  logic          fetch_en, cap, reload;
  logic          visible, hs_n, vs_n;
  logic [15:0]   pix;
  logic [11:0]   rgb_nxt;
  logic          unused_pix;

  always_comb begin
    tick   = (div_cnt == DIV_LAST);
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_nxt  = h_wrap ? '0 : h_cnt + 1'b1;
    v_nxt  = h_wrap ? (v_wrap ? '0 : v_cnt + 1'b1) : v_cnt;
    // The current period prefetches the word for the pixel pair that
    // starts at the next position.
    fetch_en = ~h_nxt[0] && (h_nxt < H_VIS_W) && (v_nxt < V_VIS_W);
    cap      = fetch_en && (div_cnt == DIV_CAP);
    // Rewind on entering the last line so the (0,0) prefetch sees FB_BASE.
    reload   = tick && h_wrap && (v_nxt == V_LAST);
    visible  = (h_cnt < H_VIS_W) && (v_cnt < V_VIS_W);
    hs_n     = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs_n     = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    pix      = h_cnt[0] ? word_buf[31:16] : word_buf[15:0];
    rgb_nxt  = (visible && disp_en) ? {pix[15:12], pix[10:7], pix[4:1]} : '0;
    unused_pix = ^{pix[11], pix[6:5], pix[0]};
  end

  // The address is held for the whole fetch period, so VRAM sees it during
  // div_cnt==0 and its data arrives for capture at the end of div_cnt==1.
  assign vram_addrb = fetch_addr;

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      fetch_addr  <= FB_BASE;
      prefetch    <= '0;
      word_buf    <= '0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (cap) prefetch <= vram_doutb;
      if (reload)   fetch_addr <= FB_BASE;
      else if (cap) fetch_addr <= fetch_addr + 18'd1;
      if (tick) begin
        h_cnt  <= h_nxt;
        v_cnt  <= v_nxt;
        // With CLK_DIV==2 the capture edge is the tick itself, so bypass
        // the prefetch register in that case.
        if (fetch_en) word_buf <= cap ? vram_doutb : prefetch;
        {vga_r, vga_g, vga_b} <= rgb_nxt;
        vga_hs <= hs_n;
        vga_vs <= vs_n;
      end
      frame_start <= tick && h_wrap && v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
module tb_vga_scanout;

  localparam int HV = 16, HF = 2, HS = 3, HB = 3, HT = HV + HF + HS + HB;
  localparam int VV = 4,  VF = 1, VS = 2, VB = 1, VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int D0 = 4, D1 = 2;
  localparam logic [17:0] B0 = 18'h00100;
  localparam logic [17:0] B1 = 18'h3FFF0;

  logic        clka, rstn, disp_en, en_edge;
  logic [17:0] addr0, addr1;
  logic [31:0] dout0, dout1;
  logic [3:0]  r0, g0, b0, r1, g1, b1;
  logic        hs0, vs0, fs0, hs1, vs1, fs1;
  int          cyc;
  int          n_tests, n_fail;

  vga_scanout #(.CLK_DIV(D0), .FB_BASE(B0), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u0 (
    .clka(clka), .rstn(rstn), .disp_en(disp_en), .vram_addrb(addr0), .vram_doutb(dout0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0), .vga_hs(hs0), .vga_vs(vs0), .frame_start(fs0));

  vga_scanout #(.CLK_DIV(D1), .FB_BASE(B1), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u1 (
    .clka(clka), .rstn(rstn), .disp_en(disp_en), .vram_addrb(addr1), .vram_doutb(dout1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hs(hs1), .vga_vs(vs1), .frame_start(fs1));

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // VRAM contents: the base word of each instance is the known pixel pair,
  // everything else is a hash of the address.
  function automatic logic [31:0] vram_word(input logic [17:0] a);
    if (a == B0 || a == B1) return 32'hF800_07E0;
    return {a[15:0] ^ 16'hC3A5, (a[15:0] * 16'h9E37) ^ 16'h5A5A};
  endfunction

  always @(posedge clka) begin
    dout0 <= vram_word(addr0);
    dout1 <= vram_word(addr1);
    en_edge <= disp_en;
  end

  always @(posedge clka or negedge rstn)
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;

  // Word offset of the pair containing pixel index pn, -1 when blank.
  function automatic int pair_off(input int pn);
    int pos, h, v;
    pos = pn % FT; h = pos % HT; v = pos / HT;
    if (h < HV && v < VV) return (v * HV + h) / 2;
    return -1;
  endfunction

  function automatic logic [11:0] exp_rgb(input logic [17:0] base, input int q, input logic en);
    int off, h;
    logic [17:0] a;
    logic [31:0] w;
    logic [15:0] p;
    off = pair_off(q);
    if (!en || off < 0) return 12'h000;
    a = base + 18'(off);
    w = vram_word(a);
    h = (q % FT) % HT;
    p = (h % 2 == 1) ? w[31:16] : w[15:0];
    return {p[15:12], p[10:7], p[4:1]};
  endfunction

  // Expected address during period p; -1 when no fetch is due.
  function automatic int exp_addr(input logic [17:0] base, input int p);
    int off;
    logic [17:0] a;
    off = pair_off(p + 1);
    if (off < 0 || (((p + 1) % FT) % HT) % 2 == 1) return -1;
    a = base + 18'(off);
    return int'(a);
  endfunction

  function automatic logic exp_hs(input int q);
    int h;
    h = (q % FT) % HT;
    return !(h >= HV + HF && h < HV + HF + HS);
  endfunction

  function automatic logic exp_vs(input int q);
    int v;
    v = (q % FT) / HT;
    return !(v >= VV + VF && v < VV + VF + VS);
  endfunction

  function automatic logic exp_fs(input int n, input int d);
    return n > 0 && n % d == 0 && (n / d) % FT == 0;
  endfunction

  task automatic test_reset();
    repeat (1656) @(negedge clka);
    rstn = 1'b0;
    #1;
    n_tests++;
    if ({addr0, r0, g0, b0, hs0, vs0, fs0} !== {B0, 12'h000, 3'b110}) begin
      n_fail++;
      $display("FAIL reset_async_u0 got addr=%h rgb=%h%h%h hs=%b vs=%b fs=%b want addr=%h rgb=000 hs=1 vs=1 fs=0",
               addr0, r0, g0, b0, hs0, vs0, fs0, B0);
    end
    n_tests++;
    if ({addr1, r1, g1, b1, hs1, vs1, fs1} !== {B1, 12'h000, 3'b110}) begin
      n_fail++;
      $display("FAIL reset_async_u1 got addr=%h rgb=%h%h%h hs=%b vs=%b fs=%b want addr=%h rgb=000 hs=1 vs=1 fs=0",
               addr1, r1, g1, b1, hs1, vs1, fs1, B1);
    end
    repeat (3) @(negedge clka);
    n_tests++;
    if ({addr0, hs0, vs0, fs0} !== {B0, 3'b110}) begin
      n_fail++;
      $display("FAIL reset_hold got addr=%h hs=%b vs=%b fs=%b want addr=%h 1 1 0", addr0, hs0, vs0, fs0, B0);
    end
    rstn = 1'b1;
    repeat (D0) @(negedge clka);
    n_tests++;
    if ({r0, g0, b0, hs0, vs0, fs0} !== {12'h000, 3'b110}) begin
      n_fail++;
      $display("FAIL first_tick got rgb=%h%h%h hs=%b vs=%b fs=%b want rgb=000 hs=1 vs=1 fs=0",
               r0, g0, b0, hs0, vs0, fs0);
    end
    n_tests++;
    if (addr0 !== B0) begin
      n_fail++;
      $display("FAIL first_tick_addr got %h want %h", addr0, B0);
    end
  endtask

  task automatic test_timing();
    int n, last0, last1, cnt0, cnt1;
    last0 = -1; last1 = -1; cnt0 = 0; cnt1 = 0;
    repeat (2 * FT * D0 + 8) begin
      @(negedge clka);
      n = cyc;
      if (n % D0 == 0) begin
        n_tests++;
        if ({hs0, vs0} !== {exp_hs(n / D0 - 1), exp_vs(n / D0 - 1)}) begin
          n_fail++;
          $display("FAIL sync_u0 n=%0d got hs=%b vs=%b want hs=%b vs=%b", n, hs0, vs0,
                   exp_hs(n / D0 - 1), exp_vs(n / D0 - 1));
        end
      end
      if (n % D1 == 0) begin
        n_tests++;
        if ({hs1, vs1} !== {exp_hs(n / D1 - 1), exp_vs(n / D1 - 1)}) begin
          n_fail++;
          $display("FAIL sync_u1 n=%0d got hs=%b vs=%b want hs=%b vs=%b", n, hs1, vs1,
                   exp_hs(n / D1 - 1), exp_vs(n / D1 - 1));
        end
      end
      n_tests++;
      if ({fs0, fs1} !== {exp_fs(n, D0), exp_fs(n, D1)}) begin
        n_fail++;
        $display("FAIL frame_start n=%0d got %b%b want %b%b", n, fs0, fs1, exp_fs(n, D0), exp_fs(n, D1));
      end
      if (fs0 === 1'b1) begin
        if (last0 >= 0) begin
          n_tests++;
          if (n - last0 != FT * D0) begin
            n_fail++;
            $display("FAIL fs_period_u0 got %0d want %0d", n - last0, FT * D0);
          end
        end
        last0 = n; cnt0++;
      end
      if (fs1 === 1'b1) begin
        if (last1 >= 0) begin
          n_tests++;
          if (n - last1 != FT * D1) begin
            n_fail++;
            $display("FAIL fs_period_u1 got %0d want %0d", n - last1, FT * D1);
          end
        end
        last1 = n; cnt1++;
      end
    end
    n_tests++;
    if (cnt0 != 2 || cnt1 != 4) begin
      n_fail++;
      $display("FAIL fs_count got %0d/%0d want 2/4", cnt0, cnt1);
    end
  endtask

  task automatic test_pixels();
    int n, q, ea;
    repeat (3 * FT * D0) begin
      @(negedge clka);
      n = cyc;
      if (n % D0 == 0 && n / D0 - 1 >= FT) begin
        q = n / D0 - 1;
        n_tests++;
        if ({r0, g0, b0} !== exp_rgb(B0, q, 1'b1)) begin
          n_fail++;
          $display("FAIL pixel_u0 q=%0d got %h%h%h want %h", q, r0, g0, b0, exp_rgb(B0, q, 1'b1));
        end
        if (q % FT == 0 || q % FT == 1) begin
          n_tests++;
          if ({r0, g0, b0} !== ((q % FT == 0) ? 12'h0F0 : 12'hF00)) begin
            n_fail++;
            $display("FAIL pixel_order_u0 q=%0d got %h%h%h", q, r0, g0, b0);
          end
        end
        ea = exp_addr(B0, n / D0);
        if (ea >= 0) begin
          n_tests++;
          if (addr0 !== 18'(ea)) begin
            n_fail++;
            $display("FAIL addr_u0 n=%0d got %h want %h", n, addr0, 18'(ea));
          end
        end
        if ((n / D0) % FT == 3 * HT + HV) begin
          n_tests++;
          if (addr0 !== B0 + 18'd32) begin
            n_fail++;
            $display("FAIL addr_end_u0 got %h want %h", addr0, B0 + 18'd32);
          end
        end
        if ((n / D0) % FT == (VT - 1) * HT) begin
          n_tests++;
          if (addr0 !== B0) begin
            n_fail++;
            $display("FAIL addr_reload_u0 got %h want %h", addr0, B0);
          end
        end
      end
      if (n % D1 == 0 && n / D1 - 1 >= FT) begin
        q = n / D1 - 1;
        n_tests++;
        if ({r1, g1, b1} !== exp_rgb(B1, q, 1'b1)) begin
          n_fail++;
          $display("FAIL pixel_u1 q=%0d got %h%h%h want %h", q, r1, g1, b1, exp_rgb(B1, q, 1'b1));
        end
        ea = exp_addr(B1, n / D1);
        if (ea >= 0) begin
          n_tests++;
          if (addr1 !== 18'(ea)) begin
            n_fail++;
            $display("FAIL addr_u1 n=%0d got %h want %h", n, addr1, 18'(ea));
          end
        end
        if ((n / D1) % FT == 3 * HT + HV) begin
          n_tests++;
          if (addr1 !== 18'h00010) begin
            n_fail++;
            $display("FAIL addr_end_u1 got %h want 00010", addr1);
          end
        end
      end
    end
  endtask

  task automatic test_disp_en();
    int n, k;
    k = 0;
    repeat (1200) begin
      @(negedge clka);
      n = cyc;
      if (n % D0 == 0) begin
        n_tests++;
        if ({r0, g0, b0, hs0, vs0} !== {exp_rgb(B0, n / D0 - 1, en_edge), exp_hs(n / D0 - 1), exp_vs(n / D0 - 1)}) begin
          n_fail++;
          $display("FAIL disp_en_u0 n=%0d en=%b got %h%h%h hs=%b vs=%b want %h", n, en_edge, r0, g0, b0,
                   hs0, vs0, exp_rgb(B0, n / D0 - 1, en_edge));
        end
      end
      if (n % D1 == 0) begin
        n_tests++;
        if ({r1, g1, b1, hs1, vs1} !== {exp_rgb(B1, n / D1 - 1, en_edge), exp_hs(n / D1 - 1), exp_vs(n / D1 - 1)}) begin
          n_fail++;
          $display("FAIL disp_en_u1 n=%0d en=%b got %h%h%h hs=%b vs=%b want %h", n, en_edge, r1, g1, b1,
                   hs1, vs1, exp_rgb(B1, n / D1 - 1, en_edge));
        end
      end
      k++;
      if (k == 301) disp_en = 1'b0;
      if (k == 803) disp_en = 1'b1;
    end
  endtask

  task automatic test_wrap();
    logic [17:0] prev;
    logic        seen;
    seen = 1'b0;
    prev = addr1;
    repeat (FT * D1 * 2) begin
      @(negedge clka);
      n_tests++;
      if ($isunknown(addr1) || $isunknown({r1, g1, b1})) begin
        n_fail++;
        $display("FAIL wrap_unknown got addr=%h rgb=%h%h%h", addr1, r1, g1, b1);
      end
      if (prev == 18'h3FFFF && addr1 != prev) begin
        seen = 1'b1;
        n_tests++;
        if (addr1 !== 18'h00000) begin
          n_fail++;
          $display("FAIL wrap_next got %h want 00000", addr1);
        end
      end
      prev = addr1;
    end
    n_tests++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_seen got %b want 1", seen);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rstn = 1'b0; disp_en = 1'b1;
    repeat (3) @(negedge clka);
    rstn = 1'b1;
    test_reset();
    test_timing();
    test_pixels();
    test_disp_en();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
